// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a UART transmitter through a launch FSM.
// Host writes bytes; the FSM pops one per frame and pulses tx_start.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   wr_en, wr_data host byte write strobe and data
//   full, empty    registered occupancy flags
//   count          registered occupancy 0..DEPTH
//   overflow       sticky: a write arrived while full and was dropped
//   tx_data        byte presented to the transmitter
//   tx_start       one-cycle launch pulse
//   tx_busy        transmitter frame in progress
//   tx_done        transmitter frame-complete pulse
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic [7:0]       tx_data,
  output logic             tx_start,
  input  logic             tx_busy,
  input  logic             tx_done
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_n;

  logic [7:0]       mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] count_n;
  logic             wr_ok;
  logic             pop;

  // full is the registered flag, so a write in the same cycle as a
  // pop from a full FIFO is still dropped.
  assign wr_ok = wr_en && !full;

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty && !tx_busy) begin
          pop     = 1'b1;
          state_n = LAUNCH;
        end
      end
      LAUNCH: begin
        state_n = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (tx_done) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_comb begin
    count_n = count;
    unique case ({wr_ok, pop})
      2'b10:   count_n = count + CNT_ONE;
      2'b01:   count_n = count - CNT_ONE;
      default: count_n = count;
    endcase
  end

  assign tx_start = (state == LAUNCH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      overflow <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      state <= state_n;
      count <= count_n;
      empty <= (count_n == CNT_ZERO);
      full  <= (count_n == CNT_FULL);
      if (wr_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
      if (pop) begin
        tx_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + PTR_ONE;
      end
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed vector table plus multi-cycle sequences
// with a loopback transmitter model for uart_tx_fifo.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int CNT_W = 5;
  localparam int NV = 21;
  localparam int FL = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             wr_en = 1'b0;
  logic [7:0]       wr_data = 8'h00;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic [7:0]       tx_data;
  logic             tx_start;
  logic             tx_busy = 1'b0;
  logic             tx_done = 1'b0;

  uart_tx_fifo #(
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .empty   (empty),
    .count   (count),
    .overflow(overflow),
    .tx_data (tx_data),
    .tx_start(tx_start),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       wr;
    logic [7:0] wd;
    logic       busy;
    logic       done;
    int         cnt;
    logic       emp;
    logic       ful;
    logic       ovf;
    logic       st;
    logic [7:0] txd;
  } vec_t;

  vec_t vt [NV];

  int checks = 0;
  int errors = 0;

  logic [7:0] wq [$];
  logic [7:0] expq [$];
  logic [7:0] rxq [$];

  function automatic vec_t mk(input int r, input int w, input int d,
                              input int b, input int dn, input int c,
                              input int e, input int f, input int o,
                              input int s, input int t);
    vec_t v;
    v.rst  = r[0];
    v.wr   = w[0];
    v.wd   = d[7:0];
    v.busy = b[0];
    v.done = dn[0];
    v.cnt  = c;
    v.emp  = e[0];
    v.ful  = f[0];
    v.ovf  = o[0];
    v.st   = s[0];
    v.txd  = t[7:0];
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input int cnt, input logic emp,
                         input logic ful, input logic ovf, input logic st,
                         input logic [7:0] txd);
    chk({nm, " count"}, 32'(count), 32'(cnt));
    chk({nm, " empty"}, 32'(empty), 32'(emp));
    chk({nm, " full"}, 32'(full), 32'(ful));
    chk({nm, " overflow"}, 32'(overflow), 32'(ovf));
    chk({nm, " tx_start"}, 32'(tx_start), 32'(st));
    chk({nm, " tx_data"}, 32'(tx_data), 32'(txd));
  endtask

  task automatic do_reset(input string nm);
    rst     = 1'b1;
    wr_en   = 1'b0;
    tx_busy = 1'b0;
    tx_done = 1'b0;
    step();
    chk_out(nm, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    rst = 1'b0;
  endtask

  task automatic fill(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = first + 8'(i);
      step();
    end
    wr_en = 1'b0;
  endtask

  // Loopback transmitter: answers each tx_start with a FL-cycle busy
  // frame ending in a tx_done pulse, and records the launched byte.
  task automatic stream(input string nm, input int max_pend,
                        input int budget);
    int fcnt;
    int starts;
    int nw;
    int cyc;
    int overlap;
    int total;
    fcnt    = 0;
    starts  = 0;
    nw      = 0;
    cyc     = 0;
    overlap = 0;
    total   = expq.size();
    rxq.delete();
    tx_busy = 1'b0;
    tx_done = 1'b0;
    while ((starts < total || wq.size() > 0 || fcnt > 0 || tx_done)
           && cyc < budget) begin
      if (wq.size() > 0 && (nw - starts) < max_pend) begin
        wr_en   = 1'b1;
        wr_data = wq.pop_front();
        nw++;
      end else begin
        wr_en = 1'b0;
      end
      step();
      cyc++;
      tx_done = 1'b0;
      if (tx_start) begin
        rxq.push_back(tx_data);
        starts++;
        if (fcnt != 0) overlap++;
        fcnt    = FL;
        tx_busy = 1'b1;
      end else if (fcnt > 0) begin
        fcnt--;
        if (fcnt == 0) begin
          tx_busy = 1'b0;
          tx_done = 1'b1;
        end
      end
    end
    wr_en   = 1'b0;
    tx_done = 1'b0;
    tx_busy = 1'b0;
    chk({nm, " timeout"}, 32'(cyc >= budget), 32'd0);
    chk({nm, " overlap"}, 32'(overlap), 32'd0);
    chk({nm, " starts"}, 32'(starts), 32'(total));
    for (int i = 0; i < total; i++) begin
      chk($sformatf("%s byte%0d", nm, i),
          (i < rxq.size()) ? 32'(rxq[i]) : 32'hFFFF_FFFF,
          32'(expq[i]));
    end
  endtask

  initial begin
    int n;

    vt[0]  = mk(1, 0, 'h00, 0, 0, 0, 1, 0, 0, 0, 'h00);
    vt[1]  = mk(0, 1, 'h08, 0, 0, 1, 0, 0, 0, 0, 'h00);
    vt[2]  = mk(0, 0, 'h00, 0, 0, 0, 1, 0, 0, 1, 'h08);
    vt[3]  = mk(0, 0, 'h00, 0, 0, 0, 1, 0, 0, 0, 'h08);
    vt[4]  = mk(0, 0, 'h00, 0, 0, 0, 1, 0, 0, 0, 'h08);
    vt[5]  = mk(0, 0, 'h00, 0, 1, 0, 1, 0, 0, 0, 'h08);
    vt[6]  = mk(0, 1, 'h31, 1, 0, 1, 0, 0, 0, 0, 'h08);
    vt[7]  = mk(0, 0, 'h00, 1, 0, 1, 0, 0, 0, 0, 'h08);
    vt[8]  = mk(0, 0, 'h00, 0, 0, 0, 1, 0, 0, 1, 'h31);
    vt[9]  = mk(0, 0, 'h00, 0, 1, 0, 1, 0, 0, 0, 'h31);
    vt[10] = mk(0, 1, 'h69, 0, 0, 1, 0, 0, 0, 0, 'h31);
    vt[11] = mk(0, 0, 'h00, 0, 0, 1, 0, 0, 0, 0, 'h31);
    vt[12] = mk(0, 0, 'h00, 0, 1, 1, 0, 0, 0, 0, 'h31);
    vt[13] = mk(0, 0, 'h00, 0, 0, 0, 1, 0, 0, 1, 'h69);
    vt[14] = mk(0, 0, 'h00, 0, 0, 0, 1, 0, 0, 0, 'h69);
    vt[15] = mk(1, 0, 'h00, 0, 0, 0, 1, 0, 0, 0, 'h00);
    vt[16] = mk(0, 0, 'h00, 0, 1, 0, 1, 0, 0, 0, 'h00);
    vt[17] = mk(0, 1, 'h23, 0, 1, 1, 0, 0, 0, 0, 'h00);
    vt[18] = mk(0, 0, 'h00, 0, 0, 0, 1, 0, 0, 1, 'h23);
    vt[19] = mk(0, 0, 'h00, 0, 1, 0, 1, 0, 0, 0, 'h23);
    vt[20] = mk(0, 0, 'h00, 0, 1, 0, 1, 0, 0, 0, 'h23);

    for (int i = 0; i < NV; i++) begin
      rst     = vt[i].rst;
      wr_en   = vt[i].wr;
      wr_data = vt[i].wd;
      tx_busy = vt[i].busy;
      tx_done = vt[i].done;
      step();
      chk_out($sformatf("vec%0d", i), vt[i].cnt, vt[i].emp,
              vt[i].ful, vt[i].ovf, vt[i].st, vt[i].txd);
    end
    rst     = 1'b0;
    wr_en   = 1'b0;
    tx_busy = 1'b0;
    tx_done = 1'b0;

    // Burst through the loopback model
    do_reset("burst rst");
    wq   = '{8'h08, 8'h31, 8'h69, 8'h23, 8'hBB};
    expq = '{8'h08, 8'h31, 8'h69, 8'h23, 8'hBB};
    stream("burst", DEPTH, 400);

    // Fill to full with one extra byte, then drain
    do_reset("full rst");
    tx_busy = 1'b1;
    fill(8'h00, 17);
    chk_out("full", 16, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    wq.delete();
    expq.delete();
    for (int i = 0; i < 16; i++) expq.push_back(8'(i));
    stream("drain", DEPTH, 600);
    chk_out("drained", 0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h0F);

    // Write in the pop cycle of a full FIFO is dropped
    do_reset("simul rst");
    tx_busy = 1'b1;
    fill(8'h40, 16);
    chk_out("simul full", 16, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    tx_busy = 1'b0;
    wr_en   = 1'b1;
    wr_data = 8'hEE;
    step();
    wr_en = 1'b0;
    chk_out("simul pop", 15, 1'b0, 1'b0, 1'b1, 1'b1, 8'h40);
    tx_busy = 1'b1;
    step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    wq.delete();
    expq.delete();
    for (int i = 1; i < 16; i++) expq.push_back(8'h40 + 8'(i));
    stream("simul", DEPTH, 600);

    // Pointer wrap: 40 bytes interleaved with frames
    do_reset("wrap rst");
    wq.delete();
    expq.delete();
    for (int i = 0; i < 40; i++) begin
      wq.push_back(8'((i * 37 + 5) & 255));
      expq.push_back(8'((i * 37 + 5) & 255));
    end
    stream("wrap", DEPTH, 3000);

    // Reset in WAIT_DONE with three bytes still queued
    do_reset("mid rst0");
    tx_busy = 1'b1;
    fill(8'h11, 4);
    tx_busy = 1'b0;
    step();
    chk_out("mid pop", 3, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11);
    tx_busy = 1'b1;
    step();
    chk_out("mid wait", 3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11);
    rst     = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'h77;
    step();
    chk_out("mid rst", 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    rst     = 1'b0;
    wr_en   = 1'b0;
    tx_busy = 1'b0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (tx_start) n++;
    end
    chk("mid no start", 32'(n), 32'd0);
    chk("mid count", 32'(count), 32'd0);
    wq   = '{8'h5A};
    expq = '{8'h5A};
    stream("mid new", DEPTH, 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
